// File: rtl/computer_4bit.sv
// Single-clock 4-bit accumulator CPU: 16x8 instruction memory, 16x4 data memory, 16x4 stack.
// Memories load while rst is high; execution runs one instruction per clock from address 0 until HLT.
module computer_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_in,
  input  logic [3:0] ins_address,
  input  logic [7:0] ins,
  output logic [3:0] d_out,
  output logic       ZF,
  output logic       CF
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB   = 4'h1, OP_XCHG  = 4'h2, OP_LDA_M = 4'h3,
    OP_OUT   = 4'h4, OP_LDA_I = 4'h5, OP_LDB_M = 4'h6, OP_LDB_I = 4'h7,
    OP_STA   = 4'h8, OP_PUSH  = 4'h9, OP_POP   = 4'hA, OP_JMP   = 4'hB,
    OP_JZ    = 4'hC, OP_AND   = 4'hD, OP_TEST  = 4'hE, OP_HLT   = 4'hF
  } op_e;

  logic [7:0] im_q  [16];
  logic [3:0] dm_q  [16];
  logic [3:0] stk_q [16];

  logic [3:0] pc_q, pc_d, sp_q, sp_d, a_q, a_d, b_q, b_d, dout_q, dout_d;
  logic       zf_q, zf_d, cf_q, cf_d, halt_q, halt_d;
  logic       dm_we, stk_we;

  logic [7:0] instr;
  op_e        op;
  logic [3:0] n;
  logic [4:0] sum5, diff5;
  logic [3:0] and4;

  function automatic logic is_zero(input logic [3:0] v);
    return (v == 4'h0);
  endfunction

  assign instr = im_q[pc_q];
  assign op    = op_e'(instr[3:0]);
  assign n     = instr[7:4];
  assign sum5  = {1'b0, a_q} + {1'b0, b_q};
  assign diff5 = {1'b0, a_q} - {1'b0, b_q};
  assign and4  = a_q & b_q;

  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    a_d    = a_q;
    b_d    = b_q;
    dout_d = dout_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    halt_d = halt_q;
    dm_we  = 1'b0;
    stk_we = 1'b0;
    if (!halt_q) begin
      pc_d = pc_q + 4'd1;
      case (op)
        OP_ADD:   begin a_d = sum5[3:0];  cf_d = sum5[4];  zf_d = is_zero(sum5[3:0]);  end
        // Bit 4 of the 5-bit difference is set exactly when A < B.
        OP_SUB:   begin a_d = diff5[3:0]; cf_d = diff5[4]; zf_d = is_zero(diff5[3:0]); end
        OP_XCHG:  begin a_d = b_q; b_d = a_q; end
        OP_LDA_M: a_d = dm_q[n];
        OP_OUT:   dout_d = a_q;
        OP_LDA_I: a_d = n;
        OP_LDB_M: b_d = dm_q[n];
        OP_LDB_I: b_d = n;
        OP_STA:   dm_we = 1'b1;
        OP_PUSH:  begin stk_we = 1'b1; sp_d = sp_q + 4'd1; end
        OP_POP:   begin a_d = stk_q[sp_q - 4'd1]; sp_d = sp_q - 4'd1; end
        OP_JMP:   pc_d = n;
        OP_JZ:    if (zf_q) pc_d = n;
        OP_AND:   begin a_d = and4; zf_d = is_zero(and4); cf_d = 1'b0; end
        OP_TEST:  begin zf_d = is_zero(and4); cf_d = 1'b0; end
        OP_HLT:   begin halt_d = 1'b1; pc_d = pc_q; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= 4'h0;
      sp_q   <= 4'h0;
      a_q    <= 4'h0;
      b_q    <= 4'h0;
      dout_q <= 4'h0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      a_q    <= a_d;
      b_q    <= b_d;
      dout_q <= dout_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      halt_q <= halt_d;
    end
  end

  // Memories are never cleared; rst doubles as the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q[ins_address] <= ins;
      dm_q[ins_address] <= d_in;
    end else if (dm_we) begin
      dm_q[n] <= a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && stk_we) stk_q[sp_q] <= a_q;
  end

  assign d_out = dout_q;
  assign ZF    = zf_q;
  assign CF    = cf_q;

endmodule

// File: tb/tb_computer_4bit.sv
// Directed bench for computer_4bit: each task loads a small program and checks d_out/ZF/CF.
module tb_computer_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d_in = 4'h0;
  logic [3:0] ins_address = 4'h0;
  logic [7:0] ins = 8'h0F;
  logic [3:0] d_out;
  logic       ZF, CF;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [16];
  logic [3:0] dmv  [16];

  computer_4bit dut (
    .clk(clk), .rst(rst), .d_in(d_in), .ins_address(ins_address),
    .ins(ins), .d_out(d_out), .ZF(ZF), .CF(CF)
  );

  always #5 clk = ~clk;

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h0F;
      dmv[i]  = 4'h0;
    end
  endtask

  // Holds reset across 16 load edges, then releases at a falling edge.
  task automatic load_prog();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ins_address = i[3:0];
      ins         = prog[i];
      d_in        = dmv[i];
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic run_edges(input int cnt);
    repeat (cnt) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (d_out !== 4'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    checks++; if (ZF !== 1'b0) begin errors++; $display("FAIL reset_zf: got %b expected 0", ZF); end
    checks++; if (CF !== 1'b0) begin errors++; $display("FAIL reset_cf: got %b expected 0", CF); end
  endtask

  task automatic test_load_xchg();
    clear_prog();
    prog[0] = 8'h16; prog[1] = 8'h02; prog[2] = 8'h17;
    prog[3] = 8'h0E; prog[4] = 8'h04; prog[5] = 8'h0F;
    dmv[1] = 4'h8;
    load_prog();
    run_edges(6);
    checks++; if (d_out !== 4'h8) begin errors++; $display("FAIL xchg_dout: got %h expected 8", d_out); end
    checks++; if (ZF !== 1'b1) begin errors++; $display("FAIL xchg_zf: got %b expected 1", ZF); end
    checks++; if (CF !== 1'b0) begin errors++; $display("FAIL xchg_cf: got %b expected 0", CF); end
    run_edges(5);
    checks++; if (d_out !== 4'h8) begin errors++; $display("FAIL halt_dout: got %h expected 8", d_out); end
    checks++; if (ZF !== 1'b1) begin errors++; $display("FAIL halt_zf: got %b expected 1", ZF); end
  endtask

  task automatic test_carry();
    clear_prog();
    prog[0] = 8'h95; prog[1] = 8'h77; prog[2] = 8'h00; prog[3] = 8'h04;
    load_prog();
    run_edges(6);
    checks++; if (d_out !== 4'h0) begin errors++; $display("FAIL carry_dout: got %h expected 0", d_out); end
    checks++; if (CF !== 1'b1) begin errors++; $display("FAIL carry_cf: got %b expected 1", CF); end
    checks++; if (ZF !== 1'b1) begin errors++; $display("FAIL carry_zf: got %b expected 1", ZF); end
  endtask

  task automatic test_borrow();
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h57; prog[2] = 8'h01; prog[3] = 8'h04;
    load_prog();
    run_edges(6);
    checks++; if (d_out !== 4'hE) begin errors++; $display("FAIL borrow_dout: got %h expected e", d_out); end
    checks++; if (CF !== 1'b1) begin errors++; $display("FAIL borrow_cf: got %b expected 1", CF); end
    checks++; if (ZF !== 1'b0) begin errors++; $display("FAIL borrow_zf: got %b expected 0", ZF); end
  endtask

  task automatic test_stack_mem();
    clear_prog();
    prog[0] = 8'hA5; prog[1] = 8'h09; prog[2] = 8'h05; prog[3] = 8'h0A;
    prog[4] = 8'hF8; prog[5] = 8'hF3; prog[6] = 8'h04; prog[7] = 8'h0F;
    load_prog();
    run_edges(9);
    checks++; if (d_out !== 4'hA) begin errors++; $display("FAIL stack_dout: got %h expected a", d_out); end
  endtask

  // POP from empty stack reads STK[15]; PUSH at SP=15 wraps SP to 0.
  task automatic test_stack_wrap();
    clear_prog();
    prog[0] = 8'h0A; prog[1] = 8'h65; prog[2] = 8'h09; prog[3] = 8'h05;
    prog[4] = 8'h0A; prog[5] = 8'h04; prog[6] = 8'h0F;
    load_prog();
    run_edges(8);
    checks++; if (d_out !== 4'h6) begin errors++; $display("FAIL stkwrap_dout: got %h expected 6", d_out); end
  endtask

  task automatic test_jz_taken();
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h07; prog[2] = 8'h0E; prog[3] = 8'h5C;
    prog[4] = 8'h04; prog[5] = 8'h95; prog[6] = 8'h04; prog[7] = 8'h0F;
    load_prog();
    run_edges(5);
    checks++; if (d_out !== 4'h0) begin errors++; $display("FAIL jz_skip_dout: got %h expected 0", d_out); end
    checks++; if (ZF !== 1'b1) begin errors++; $display("FAIL jz_zf: got %b expected 1", ZF); end
    run_edges(3);
    checks++; if (d_out !== 4'h9) begin errors++; $display("FAIL jz_target_dout: got %h expected 9", d_out); end
  endtask

  task automatic test_jz_not_taken();
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h77; prog[2] = 8'h0E; prog[3] = 8'h5C;
    prog[4] = 8'h04; prog[5] = 8'h0F; prog[6] = 8'h95; prog[7] = 8'h04;
    load_prog();
    run_edges(8);
    checks++; if (d_out !== 4'h3) begin errors++; $display("FAIL jznt_dout: got %h expected 3", d_out); end
    checks++; if (ZF !== 1'b0) begin errors++; $display("FAIL jznt_zf: got %b expected 0", ZF); end
  endtask

  task automatic test_jmp();
    clear_prog();
    prog[0] = 8'h3B; prog[1] = 8'h15; prog[2] = 8'h04;
    prog[3] = 8'h25; prog[4] = 8'h04; prog[5] = 8'h0F;
    load_prog();
    run_edges(6);
    checks++; if (d_out !== 4'h2) begin errors++; $display("FAIL jmp_dout: got %h expected 2", d_out); end
  endtask

  // ADD sets CF/ZF, loads preserve them, AND then clears CF.
  task automatic test_and_flags();
    clear_prog();
    prog[0] = 8'hF5; prog[1] = 8'h17; prog[2] = 8'h00; prog[3] = 8'hC5;
    prog[4] = 8'hA7; prog[5] = 8'h0D; prog[6] = 8'h04; prog[7] = 8'h0F;
    load_prog();
    run_edges(5);
    checks++; if (CF !== 1'b1) begin errors++; $display("FAIL keep_cf: got %b expected 1", CF); end
    checks++; if (ZF !== 1'b1) begin errors++; $display("FAIL keep_zf: got %b expected 1", ZF); end
    run_edges(4);
    checks++; if (d_out !== 4'h8) begin errors++; $display("FAIL and_dout: got %h expected 8", d_out); end
    checks++; if (CF !== 1'b0) begin errors++; $display("FAIL and_cf: got %b expected 0", CF); end
    checks++; if (ZF !== 1'b0) begin errors++; $display("FAIL and_zf: got %b expected 0", ZF); end
  endtask

  task automatic test_async_reset();
    clear_prog();
    prog[0] = 8'h35; prog[1] = 8'h57; prog[2] = 8'h01; prog[3] = 8'h04;
    load_prog();
    run_edges(4);
    checks++; if (d_out !== 4'hE) begin errors++; $display("FAIL pre_rst_dout: got %h expected e", d_out); end
    // Pulse reset entirely inside the low clock phase so no load edge occurs.
    #1 rst = 1'b1;
    #1;
    checks++; if (d_out !== 4'h0) begin errors++; $display("FAIL async_dout: got %h expected 0", d_out); end
    checks++; if (CF !== 1'b0) begin errors++; $display("FAIL async_cf: got %b expected 0", CF); end
    checks++; if (ZF !== 1'b0) begin errors++; $display("FAIL async_zf: got %b expected 0", ZF); end
    #1 rst = 1'b0;
    run_edges(3);
    checks++; if (CF !== 1'b1) begin errors++; $display("FAIL restart_cf: got %b expected 1", CF); end
    checks++; if (d_out !== 4'h0) begin errors++; $display("FAIL restart_dout3: got %h expected 0", d_out); end
    run_edges(1);
    checks++; if (d_out !== 4'hE) begin errors++; $display("FAIL restart_dout4: got %h expected e", d_out); end
  endtask

  initial begin
    test_reset();
    test_load_xchg();
    test_carry();
    test_borrow();
    test_stack_mem();
    test_stack_wrap();
    test_jz_taken();
    test_jz_not_taken();
    test_jmp();
    test_and_flags();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
